// File: rtl/apb_master_bridge.sv
// APB4 requester: valid/ready request/response port to APB transfers, one outstanding at a time.
// Optional ACCESS-phase timeout is built when APB_MASTER_TIMEOUT_EN is defined.
package apb_pkg;

  typedef struct packed {
    logic        psel;
    logic        pwrite;
    logic        penable;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
  } apb_h2d_t;

  typedef struct packed {
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
  } apb_d2h_t;

  typedef enum logic [1:0] {
    StateIdle   = 2'd0,
    StateSetup  = 2'd1,
    StateAccess = 2'd2
  } apb_state_e;

endpackage

module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_strb_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output apb_h2d_t    apb_o,
  input  apb_d2h_t    apb_i
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("apb_master_bridge: TIMEOUT_CYCLES must be in 2..65535");
  end

  apb_state_e  state_q, state_d;
  apb_h2d_t    apb_q, apb_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] cnt_q, cnt_d;
`endif

  // Reset is folded in so the requester sees no acceptance window while rst_i is held.
  assign req_ready_o = (state_q == StateIdle) && !rsp_valid_q && !rst_i;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign apb_o       = apb_q;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    state_d     = state_q;
    apb_d       = apb_q;
    rsp_valid_d = rsp_valid_q && !rsp_ready_i;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
`ifdef APB_MASTER_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif

    case (state_q)
      StateIdle: begin
        if (req_valid_i && req_ready_o) begin
          apb_d.psel    = 1'b1;
          apb_d.penable = 1'b0;
          apb_d.pwrite  = req_write_i;
          apb_d.paddr   = req_addr_i;
          apb_d.pwdata  = req_write_i ? req_wdata_i : 32'h0;
          apb_d.pstrb   = req_write_i ? req_strb_i  : 4'h0;
          state_d       = StateSetup;
        end
      end
      StateSetup: begin
        apb_d.penable = 1'b1;
        state_d       = StateAccess;
`ifdef APB_MASTER_TIMEOUT_EN
        cnt_d         = '0;
`endif
      end
      StateAccess: begin
        if (apb_i.pready) begin
          rsp_rdata_d   = apb_q.pwrite ? 32'h0 : apb_i.prdata;
          rsp_err_d     = apb_i.pslverr;
          rsp_valid_d   = 1'b1;
          apb_d.psel    = 1'b0;
          apb_d.penable = 1'b0;
          state_d       = StateIdle;
        end
`ifdef APB_MASTER_TIMEOUT_EN
        else if (cnt_q == TimeoutLast) begin
          rsp_rdata_d   = 32'h0;
          rsp_err_d     = 1'b1;
          rsp_valid_d   = 1'b1;
          apb_d.psel    = 1'b0;
          apb_d.penable = 1'b0;
          state_d       = StateIdle;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      default: begin
        apb_d.psel    = 1'b0;
        apb_d.penable = 1'b0;
        state_d       = StateIdle;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StateIdle;
      apb_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      apb_q       <= apb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef APB_MASTER_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: vector table, random transfers against a
// reference model, and hand sequences for backpressure, reset and (if built) timeout.
module tb_apb_master_bridge;
  import apb_pkg::*;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          waits;
    logic        slverr;
    logic [31:0] prdata;
    logic [31:0] exp_pwdata;
    logic [3:0]  exp_pstrb;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_strb = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  apb_h2d_t    h2d;
  apb_d2h_t    d2h = '0;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  apb_master_bridge #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_write_i (req_write),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .req_strb_i  (req_strb),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err),
    .apb_o       (h2d),
    .apb_i       (d2h)
  );

  task automatic check(input string name, input logic [70:0] act, input logic [70:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: what a spec-conforming APB4 requester must present and return.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    r.exp_pwdata = v.write ? v.wdata : 32'h0;
    r.exp_pstrb  = v.write ? v.strb  : 4'h0;
    r.exp_rdata  = v.write ? 32'h0   : v.prdata;
    r.exp_err    = v.slverr;
    return r;
  endfunction

  task automatic drive_req(input vec_t v);
    req_valid = 1'b1;
    req_write = v.write;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    req_strb  = v.strb;
  endtask

  task automatic issue(input vec_t v);
    check("req_ready_before_issue", 71'(req_ready), 71'(1));
    drive_req(v);
    step();
    req_valid = 1'b0;
    req_wdata = $urandom;
    req_strb  = 4'($urandom);
  endtask

  task automatic check_bus(input string tag, input vec_t v, input logic penable);
    check({tag, "_psel"},    71'(h2d.psel),    71'(1));
    check({tag, "_penable"}, 71'(h2d.penable), 71'(penable));
    check({tag, "_pwrite"},  71'(h2d.pwrite),  71'(v.write));
    check({tag, "_paddr"},   71'(h2d.paddr),   71'(v.addr));
    check({tag, "_pwdata"},  71'(h2d.pwdata),  71'(v.exp_pwdata));
    check({tag, "_pstrb"},   71'(h2d.pstrb),   71'(v.exp_pstrb));
    check({tag, "_rsp_valid"}, 71'(rsp_valid), 71'(0));
  endtask

  // Entered one cycle after the accepting edge. consume < 0 leaves the response pending.
  task automatic run_phases(input vec_t v, input int consume);
    check_bus("setup", v, 1'b0);
    d2h.pready  = (v.waits == 0);
    d2h.pslverr = (v.waits == 0) ? v.slverr : 1'b1;
    d2h.prdata  = v.prdata;
    step();
    check_bus("access", v, 1'b1);
    for (int i = 1; i <= v.waits; i++) begin
      step();
      check_bus("wait", v, 1'b1);
      if (i == v.waits) begin
        d2h.pready  = 1'b1;
        d2h.pslverr = v.slverr;
      end
    end
    step();
    d2h.pready  = 1'b0;
    d2h.pslverr = 1'b0;
    d2h.prdata  = $urandom;
    check("rsp_valid", 71'(rsp_valid), 71'(1));
    check("rsp_rdata", 71'(rsp_rdata), 71'(v.exp_rdata));
    check("rsp_err",   71'(rsp_err),   71'(v.exp_err));
    check("psel_done", 71'({h2d.psel, h2d.penable}), 71'(0));
    check("req_ready_busy", 71'(req_ready), 71'(0));
    if (consume >= 0) begin
      for (int k = 0; k < consume; k++) begin
        step();
        check("hold_valid", 71'(rsp_valid), 71'(1));
        check("hold_rdata", 71'(rsp_rdata), 71'(v.exp_rdata));
        check("hold_err",   71'(rsp_err),   71'(v.exp_err));
        check("hold_req_ready", 71'(req_ready), 71'(0));
      end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      check("rsp_cleared", 71'(rsp_valid), 71'(0));
      check("rdata_kept",  71'(rsp_rdata), 71'(v.exp_rdata));
      check("req_ready_after", 71'(req_ready), 71'(1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[5];
    vec_t v, v2;

    tbl[0] = '{1'b0, 32'h0000_0020, 32'hAAAA_5555, 4'hF, 3, 1'b0, 32'h1234_5678,
               32'h0, 4'h0, 32'h1234_5678, 1'b0};
    tbl[1] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, 32'h5A5A_5A5A,
               32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0};
    tbl[2] = '{1'b0, 32'h0000_0044, 32'h0BAD_F00D, 4'h3, 0, 1'b1, 32'hFFFF_FFFF,
               32'h0, 4'h0, 32'hFFFF_FFFF, 1'b1};
    tbl[3] = '{1'b1, 32'h8000_0004, 32'h0102_0304, 4'h5, 2, 1'b1, 32'hCAFE_0000,
               32'h0102_0304, 4'h5, 32'h0, 1'b1};
    tbl[4] = '{1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0, 1, 1'b0, 32'hA5A5_0001,
               32'h0, 4'h0, 32'hA5A5_0001, 1'b0};

    // Reset state.
    #3;
    check("rst_apb_o", 71'(h2d), 71'(0));
    check("rst_rsp", 71'({rsp_valid, rsp_err, rsp_rdata}), 71'(0));
    check("rst_req_ready", 71'(req_ready), 71'(0));
    step();
    rst = 1'b0;
    step();
    check("idle_req_ready", 71'(req_ready), 71'(1));

    foreach (tbl[i]) begin
      issue(tbl[i]);
      run_phases(tbl[i], 0);
    end

    // Backpressure: response held while a second request waits.
    v  = model('{1'b0, 32'h0000_0100, 32'h0, 4'h0, 1, 1'b0, 32'h7777_1111, 0, 0, 0, 0});
    v2 = model('{1'b1, 32'h0000_0104, 32'h3333_4444, 4'hC, 0, 1'b0, 32'h0, 0, 0, 0, 0});
    issue(v);
    run_phases(v, -1);
    drive_req(v2);
    for (int k = 0; k < 5; k++) begin
      step();
      check("bp_valid", 71'(rsp_valid), 71'(1));
      check("bp_rdata", 71'(rsp_rdata), 71'(v.exp_rdata));
      check("bp_err",   71'(rsp_err),   71'(v.exp_err));
      check("bp_req_ready", 71'(req_ready), 71'(0));
      check("bp_psel", 71'(h2d.psel), 71'(0));
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("bp_cleared", 71'(rsp_valid), 71'(0));
    check("bp_req_ready_now", 71'(req_ready), 71'(1));
    check("bp_not_started", 71'(h2d.psel), 71'(0));
    step();
    req_valid = 1'b0;
    run_phases(v2, 0);

    // Reset in the middle of ACCESS.
    v = model('{1'b1, 32'h0000_0200, 32'h1111_2222, 4'hF, 2, 1'b0, 32'h0, 0, 0, 0, 0});
    issue(v);
    d2h.pready = 1'b0;
    step();
    check("pre_rst_access", 71'({h2d.psel, h2d.penable}), 71'(3));
    rst = 1'b1;
    #1;
    check("midrst_apb_o", 71'(h2d), 71'(0));
    check("midrst_rsp_valid", 71'(rsp_valid), 71'(0));
    check("midrst_req_ready", 71'(req_ready), 71'(0));
    step();
    rst = 1'b0;
    d2h.pready = 1'b1;
    d2h.prdata = 32'hBEEF_0000;
    for (int k = 0; k < 3; k++) begin
      step();
      check("postrst_no_rsp", 71'(rsp_valid), 71'(0));
      check("postrst_req_ready", 71'(req_ready), 71'(1));
      check("postrst_psel", 71'(h2d.psel), 71'(0));
    end
    d2h = '0;

`ifdef APB_MASTER_TIMEOUT_EN
    // Prime a nonzero read result so a zeroed timeout response is observable.
    issue(tbl[2]);
    run_phases(tbl[2], 0);
    v = model('{1'b0, 32'h0000_0300, 32'h0, 4'h0, 0, 1'b0, 32'h0, 0, 0, 0, 0});
    issue(v);
    check_bus("to_setup", v, 1'b0);
    d2h.pready = 1'b0;
    step();
    for (int k = 0; k < 4; k++) begin
      check_bus("to_access", v, 1'b1);
      step();
    end
    check("to_rsp_valid", 71'(rsp_valid), 71'(1));
    check("to_rsp_err",   71'(rsp_err),   71'(1));
    check("to_rsp_rdata", 71'(rsp_rdata), 71'(0));
    check("to_psel", 71'({h2d.psel, h2d.penable}), 71'(0));
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("to_cleared", 71'(rsp_valid), 71'(0));
    issue(tbl[4]);
    run_phases(tbl[4], 0);
`endif

    // Random transfers against the reference model; waits stay below a 4-cycle timeout.
    for (int n = 0; n < 30; n++) begin
      vec_t r;
      r.write  = 1'($urandom);
      r.addr   = $urandom;
      r.wdata  = $urandom;
      r.strb   = 4'($urandom);
      r.waits  = int'($urandom_range(0, 3));
      r.slverr = ($urandom_range(0, 3) == 0);
      r.prdata = $urandom;
      r = model(r);
      issue(r);
      run_phases(r, int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
